// File: rtl/act_vec_collector.sv
// act_vec_collector: reassembles lane-valid bus into vectors and queues them in a FIFO; ACT_COLLECT_ZERO_CNT_EN adds per-vector zero-lane count
module act_vec_collector #(
  parameter int BUS_NUM          = 64,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int CNT_WIDTH        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clr,
  input  logic                                 flush,
  input  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0]  in_fixed_data,
  input  logic [BUS_NUM-1:0]                   in_fixed_data_vld,
  output logic [BUS_NUM*FIXED_DATA_WIDTH-1:0]  out_vec_data,
  output logic                                 out_vec_vld,
  input  logic                                 out_vec_rdy,
  output logic                                 out_vec_partial,
  output logic [CNT_WIDTH-1:0]                 fifo_count,
  output logic                                 err_overflow,
  output logic                                 err_collision
`ifdef ACT_COLLECT_ZERO_CNT_EN
  ,
  output logic [$clog2(BUS_NUM+1)-1:0]         out_vec_zero_cnt
`endif
);
  localparam int W  = FIXED_DATA_WIDTH;
  localparam int DW = BUS_NUM * W;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(FIFO_DEPTH);
  logic [DW-1:0]         stg_data_q, stg_data_d, nxt_data, push_data;
  logic [BUS_NUM-1:0]    stg_mask_q, stg_mask_d, nxt_mask;
  logic [DW-1:0]         mem_q [FIFO_DEPTH];
  logic [DW-1:0]         mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] part_q, part_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  ovf_q, ovf_d, coll_q, coll_d;
  logic                  full, push, pop, accept;
`ifdef ACT_COLLECT_ZERO_CNT_EN
  localparam int ZW = $clog2(BUS_NUM + 1);
  logic [ZW-1:0] zc_q [FIFO_DEPTH];
  logic [ZW-1:0] zc_d [FIFO_DEPTH];
  logic [ZW-1:0] push_zc;
`endif
  always_comb begin
    nxt_mask = stg_mask_q | in_fixed_data_vld;
    nxt_data = '0;
    push_data = '0;
`ifdef ACT_COLLECT_ZERO_CNT_EN
    push_zc = '0;
`endif
    for (int i = 0; i < BUS_NUM; i++) begin
      nxt_data[i*W +: W] = in_fixed_data_vld[i] ? in_fixed_data[i*W +: W] : stg_data_q[i*W +: W];
      push_data[i*W +: W] = nxt_mask[i] ? nxt_data[i*W +: W] : '0;
`ifdef ACT_COLLECT_ZERO_CNT_EN
      push_zc = push_zc + ZW'(push_data[i*W +: W] == '0);
`endif
    end
    full = &nxt_mask;
    push = full | (flush & |nxt_mask);
    pop = out_vec_vld & out_vec_rdy;
    // a full FIFO still accepts when its head leaves on the same edge
    accept = push & ((count_q != DEPTH) | pop);
    stg_data_d = push ? '0 : nxt_data;
    stg_mask_d = push ? '0 : nxt_mask;
    mem_d = mem_q;
    part_d = part_q;
`ifdef ACT_COLLECT_ZERO_CNT_EN
    zc_d = zc_q;
    if (accept) zc_d[wr_ptr_q] = push_zc;
`endif
    if (accept) begin
      mem_d[wr_ptr_q] = push_data;
      part_d[wr_ptr_q] = !full;
    end
    wr_ptr_d = wr_ptr_q + PW'(accept);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CNT_WIDTH'(accept) - CNT_WIDTH'(pop);
    ovf_d = ovf_q | (push & !accept);
    coll_d = coll_q | |(in_fixed_data_vld & stg_mask_q);
    if (clr) begin
      stg_data_d = '0;
      stg_mask_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d = '0;
      ovf_d = 1'b0;
      coll_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_data_q <= '0;
      stg_mask_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef ACT_COLLECT_ZERO_CNT_EN
      for (int i = 0; i < FIFO_DEPTH; i++) zc_q[i] <= '0;
`endif
      part_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      stg_data_q <= stg_data_d;
      stg_mask_q <= stg_mask_d;
      mem_q <= mem_d;
`ifdef ACT_COLLECT_ZERO_CNT_EN
      zc_q <= zc_d;
`endif
      part_q <= part_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      coll_q <= coll_d;
    end
  end
  assign out_vec_data = mem_q[rd_ptr_q];
  assign out_vec_partial = part_q[rd_ptr_q];
  assign out_vec_vld = count_q != '0;
  assign fifo_count = count_q;
  assign err_overflow = ovf_q;
  assign err_collision = coll_q;
`ifdef ACT_COLLECT_ZERO_CNT_EN
  assign out_vec_zero_cnt = zc_q[rd_ptr_q];
`endif
endmodule
